// File: rtl/serin_pkg.sv
// ---------------------------------------------------------------------------
// serin_pkg
// Shared definitions for the POKEY serial-input receiver.
//   - state_t        : receiver FSM state encoding
//   - *_DEF          : default frame geometry (data bits, oversample ratio)
//   - phase_width()  : counter width for a given oversample ratio
//   - cnt_width()    : bit-counter width able to hold 0..data_bits
//   - PHASE_W, MID_PHASE, LAST_PHASE, CNT_W : derived constants for defaults
// ---------------------------------------------------------------------------
package serin_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  function automatic int phase_width(input int oversample);
    return $clog2(oversample);
  endfunction

  // The bit counter must be able to reach data_bits itself (it increments on
  // the last data sample before the FSM moves to STOP).
  function automatic int cnt_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

  localparam int PHASE_W    = phase_width(OVERSAMPLE_DEF);
  localparam int MID_PHASE  = OVERSAMPLE_DEF / 2 - 1;
  localparam int LAST_PHASE = OVERSAMPLE_DEF - 1;
  localparam int CNT_W      = cnt_width(DATA_BITS_DEF);

endpackage

// File: rtl/serin_sequencer_if.sv
// ---------------------------------------------------------------------------
// serin_sequencer_if
// Bundles the receiver's data/handshake signals.
//   sid          : raw serial line (idle/mark = 1)
//   sample_tick  : one-cycle strobe at OVERSAMPLE x bit rate
//   ser_en       : receiver enable (0 aborts and holds IDLE)
//   irq_ack      : one-cycle pulse clearing irq_flag
//   err_clr      : one-cycle pulse clearing frame_err / overrun_err
//   serin_data   : last completed byte
//   irq_flag     : byte ready and not yet acknowledged
//   frame_err    : sticky, stop bit sampled as 0
//   overrun_err  : sticky, byte completed while irq_flag pending
//   busy         : receiver not in IDLE
// master = the side driving the line/controls, slave = the receiver.
// ---------------------------------------------------------------------------
interface serin_sequencer_if
  import serin_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);
  logic                 sid;
  logic                 sample_tick;
  logic                 ser_en;
  logic                 irq_ack;
  logic                 err_clr;
  logic [DATA_BITS-1:0] serin_data;
  logic                 irq_flag;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;

  modport master (
    output sid, sample_tick, ser_en, irq_ack, err_clr,
    input  serin_data, irq_flag, frame_err, overrun_err, busy
  );

  modport slave (
    input  sid, sample_tick, ser_en, irq_ack, err_clr,
    output serin_data, irq_flag, frame_err, overrun_err, busy
  );
endinterface

// File: rtl/serin_sync.sv
// ---------------------------------------------------------------------------
// serin_sync
// Two-flop synchroniser for the serial data pad. Both flops reset to 1 so the
// line reads as idle/mark while in reset and no false start bit is seen on
// release. Also usable for the SKSTAT direct-sid status bit.
//   i_clk : system clock
//   i_rst : asynchronous active-high reset
//   i_d   : asynchronous input
//   o_q   : synchronised output (2 clk latency)
// ---------------------------------------------------------------------------
module serin_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= 2'b11;
    end else begin
      r_chain <= {r_chain[0], i_d};
    end
  end

  assign o_q = r_chain[1];
endmodule

// File: rtl/serin_sequencer.sv
// ---------------------------------------------------------------------------
// serin_sequencer
// Receive-side controller for the POKEY serial input. Oversamples sid, finds
// the start bit, validates it at mid-bit, shifts DATA_BITS bits LSB-first,
// samples the stop bit, then loads serin_data and updates irq/error status.
//   i_clk : system clock
//   i_rst : asynchronous active-high reset, clears all state
//   s_if  : serin_sequencer_if.slave (line, tick, enable, acks, status out)
// ---------------------------------------------------------------------------
module serin_sequencer
  import serin_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  serin_sequencer_if.slave s_if
);
  localparam int PW = phase_width(OVERSAMPLE);
  localparam int CW = cnt_width(DATA_BITS);

  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_BITS - 1);

  logic w_sid_s;

  serin_sync u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (s_if.sid),
    .o_q   (w_sid_s)
  );

  state_t               r_state, w_state_next;
  logic [PW-1:0]        r_phase, w_phase_next;
  logic [CW-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [DATA_BITS-1:0] r_data, w_data_next;
  logic                 r_irq, w_irq_next;
  logic                 r_ferr, w_ferr_next;
  logic                 r_oerr, w_oerr_next;
  logic                 r_busy;
  logic                 w_done;

  // Next-state, counters and shift register.
  always_comb begin
    w_state_next   = r_state;
    w_phase_next   = r_phase;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_done         = 1'b0;

    if (!s_if.ser_en) begin
      w_state_next   = ST_IDLE;
      w_phase_next   = '0;
      w_bit_cnt_next = '0;
    end else if (s_if.sample_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_sid_s) begin
            w_state_next = ST_START;
            w_phase_next = '0;
          end
        end
        ST_START: begin
          if (r_phase == PH_MID) begin
            w_phase_next = '0;
            if (w_sid_s) begin
              // Line went back high before mid start bit: a glitch.
              w_state_next = ST_IDLE;
            end else begin
              w_bit_cnt_next = '0;
              w_state_next   = ST_DATA;
            end
          end else begin
            w_phase_next = r_phase + PW'(1);
          end
        end
        ST_DATA: begin
          if (r_phase == PH_LAST) begin
            w_phase_next   = '0;
            w_shift_next   = {w_sid_s, r_shift[DATA_BITS-1:1]};
            w_bit_cnt_next = r_bit_cnt + CW'(1);
            if (r_bit_cnt == BIT_LAST) begin
              w_state_next = ST_STOP;
            end
          end else begin
            w_phase_next = r_phase + PW'(1);
          end
        end
        ST_STOP: begin
          if (r_phase == PH_LAST) begin
            w_phase_next = '0;
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_phase_next = r_phase + PW'(1);
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Status flags: clears are applied first so a coincident set wins.
  always_comb begin
    w_data_next = r_data;
    w_irq_next  = r_irq;
    w_ferr_next = r_ferr;
    w_oerr_next = r_oerr;

    if (s_if.irq_ack) begin
      w_irq_next = 1'b0;
    end
    if (s_if.err_clr) begin
      w_ferr_next = 1'b0;
      w_oerr_next = 1'b0;
    end

    if (w_done) begin
      w_data_next = r_shift;      // loaded even on a bad stop bit
      w_irq_next  = 1'b1;
      if (!w_sid_s) begin
        w_ferr_next = 1'b1;
      end
      // An ack landing in the completion cycle means the old byte was taken.
      if (r_irq && !s_if.irq_ack) begin
        w_oerr_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_irq     <= 1'b0;
      r_ferr    <= 1'b0;
      r_oerr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_phase   <= w_phase_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_data    <= w_data_next;
      r_irq     <= w_irq_next;
      r_ferr    <= w_ferr_next;
      r_oerr    <= w_oerr_next;
      r_busy    <= (w_state_next != ST_IDLE);
    end
  end

  assign s_if.serin_data  = r_data;
  assign s_if.irq_flag    = r_irq;
  assign s_if.frame_err   = r_ferr;
  assign s_if.overrun_err = r_oerr;
  assign s_if.busy        = r_busy;
endmodule

// File: doc/serin_sequencer.md
# serin_sequencer

Receive-side controller for the POKEY serial input port. It oversamples the serial data line (SID) and detects a start bit, then shifts eight data bits LSB-first and checks the stop bit. It loads the SERIN holding register, raises the serial-input-done interrupt flag, and maintains the framing-error and overrun status bits later read through SKSTAT. It sits between the pad synchroniser and the register file, and uses a rate strobe generated by the audio-channel timers.

## Interface
- DATA_BITS, 8, data bits per frame; the frame is 1 start + DATA_BITS + 1 stop.
- OVERSAMPLE, 16, sampleTick strobes per bit period; must be a power of two and at least 4.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- sid  in  1  raw serial data line; idle/mark level is 1.
- sampleTick  in  1  one-cycle strobe at OVERSAMPLE × bit rate.
- serEn  in  1  receiver enable; 0 aborts any frame and holds the receiver in IDLE.
- irqAck  in  1  one-cycle pulse that clears irqFlag (IRQEN/IRQST service).
- errClr  in  1  one-cycle pulse that clears frameErr and overrunErr (SKRES write).
- serinData  out  DATA_BITS  last completed byte.
- irqFlag  out  1  level: a byte is ready and not yet acknowledged.
- frameErr  out  1  sticky: a stop bit was sampled as 0.
- overrunErr  out  1  sticky: a byte completed while irqFlag was still pending.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- sid passes through a 2-flop synchroniser; the synchronised value is sidS. Both flops reset to 1.
- States are IDLE, START, DATA and STOP. A phase counter (log2 OVERSAMPLE bits), a bit counter and a shift register advance only on sampleTick.
- IDLE: on a tick with sidS=0, go to START with phase←0.
- START: on each tick, phase increments. At phase = OVERSAMPLE/2−1 (mid start bit):
  - if sidS=1, the start is a glitch; return to IDLE.
  - otherwise set phase←0, bitCnt←0 and go to DATA.
- DATA: on the tick where phase = OVERSAMPLE−1, phase wraps to 0, shift ← {sidS, shift[DATA_BITS−1:1]} and bitCnt increments. After the DATA_BITS-th sample, go to STOP.
- STOP: on the tick where phase = OVERSAMPLE−1:
  - serinData ← shift.
  - irqFlag ← 1.
  - frameErr ← 1 if sidS=0.
  - overrunErr ← 1 if irqFlag=1 and irqAck=0 in that same cycle.
  - Return to IDLE. The data are loaded even when the frame is bad.
- A new start bit may be detected on the first tick after returning to IDLE.
- Simultaneous events:
  - set beats clear, for both irqAck and errClr.
  - an irqAck in the completion cycle prevents overrun but leaves irqFlag = 1.
- serEn=0 forces IDLE and zeroes phase and bitCnt. serinData, irqFlag and the error bits are held.
- Reset mid-frame returns all outputs to their reset values immediately; no partial byte survives.

## Timing
- Reset values: serinData=0, irqFlag=0, frameErr=0, overrunErr=0, busy=0, state=IDLE.
- Synchroniser latency is 2 clk cycles from a sid change to sidS.
- All outputs are registered. serinData, irqFlag and the error bits update on the clk edge of the stop-sample tick and are visible in the next cycle.
- busy rises the cycle after the start-detect tick and falls the cycle after the stop-sample or glitch-reject tick.
- Frame length from the start-detect tick to completion is OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks; that is 152 ticks with the defaults.
- No tick activity occurs between ticks. A tick that arrives while serEn=0 is ignored.

## Structure
- Shared package serin_pkg holds:
  - state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - derived constants PHASE_W = log2(OVERSAMPLE), MID_PHASE = OVERSAMPLE/2−1, LAST_PHASE = OVERSAMPLE−1, CNT_W.
- One sub-module, serin_sync: a 2-flop synchroniser with reset-to-1, reusable for the SKSTAT sid-direct bit.
- The FSM, counters, shift register and status flags live in serin_sequencer.

## Test plan
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first) with stop=1, defaults → serinData=0xA5, irqFlag=1, frameErr=0, overrunErr=0, busy low after 152 ticks.
- Frame 0x3C with stop=0 → serinData=0x3C, frameErr=1; errClr pulse → frameErr=0; errClr coincident with a second bad stop → frameErr stays 1.
- sid low for 5 ticks then high → START entered, busy=1, rejected at phase 7, back to IDLE, irqFlag=0.
- Two frames 0x11 then 0x22 with no irqAck → serinData=0x22, overrunErr=1. Repeat with irqAck in the completion cycle of 0x22 → overrunErr=0, irqFlag=1.
- Reset asserted after the 4th data bit → all outputs 0 at once. The next full frame 0x5A decodes cleanly as 0x5A.
- serEn dropped mid-frame → busy=0, serinData unchanged. Re-enable and send 0xFF → serinData=0xFF.
